lmsm_sequencer: RTL

- Expands LM/SM instructions leaving decode into one LW/SW micro-op per set bit of the 8-bit register list.
- Sits between the ID/RR pipeline register and the EX stage.
- Holds fetch/decode with a stall while a sequence is in flight; passes every other instruction through unchanged.
- Companion to hazard detection: hazard detection flags a multiple-transfer instruction, this block issues its transfers.

---
 rtl/lmsm_sequencer_if.sv | 28 ++
 rtl/lmsm_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer_if.sv
// Decode-to-EX handshake bundle for the LM/SM sequencer.
// master = pipeline side driving decode/EX controls, slave = sequencer.
interface lmsm_sequencer_if #(
    parameter int IR_W = 16
);
    logic            id_valid;
    logic [IR_W-1:0] id_ir;
    logic [IR_W-1:0] id_pc;
    logic            id_ready;
    logic            stall_if;
    logic            flush;
    logic            ex_ready;
    logic            uop_valid;
    logic [IR_W-1:0] uop_ir;
    logic [IR_W-1:0] uop_pc;
    logic            uop_first;
    logic            uop_last;

    modport master (
        output id_valid, id_ir, id_pc, flush, ex_ready,
        input  id_ready, stall_if, uop_valid, uop_ir, uop_pc, uop_first, uop_last
    );

    modport slave (
        input  id_valid, id_ir, id_pc, flush, ex_ready,
        output id_ready, stall_if, uop_valid, uop_ir, uop_pc, uop_first, uop_last
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into one LW/SW micro-op per set bit of the register list,
// stalling fetch/decode while a sequence is in flight. Everything else
// passes through the registered micro-op slot with one cycle of latency.
module lmsm_sequencer #(
    parameter int IR_W      = 16,
    parameter bit ORDER_ASC = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    lmsm_sequencer_if.slave bus
);
    typedef enum logic {IDLE, SEQ} state_t;

    state_t          state_q;
    logic [7:0]      mask_q;
    logic [2:0]      k_q;
    logic [IR_W-1:0] uop_ir_q;
    logic [IR_W-1:0] uop_pc_q;
    logic            uop_valid_q;
    logic            uop_first_q;
    logic            uop_last_q;

    logic        load_ok;
    logic        id_ready;
    logic        accept;
    logic        is_multi;
    logic [7:0]  src_mask;
    logic [2:0]  sel_idx;
    logic [7:0]  rem_mask;
    logic [3:0]  uop_opc;
    logic [2:0]  uop_ra;
    logic [2:0]  uop_k;
    logic [15:0] uop16;

    // Priority encoder: lowest set bit when ascending, highest otherwise.
    function automatic logic [2:0] pick(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        if (ORDER_ASC) begin
            for (int i = 7; i >= 0; i--)
                if (m[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i < 8; i++)
                if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Handshake and next micro-op composition. In SEQ the opcode and base
    // register are recovered from the micro-op already in the slot, so no
    // separate copy of the original instruction is kept.
    always_comb begin
        load_ok  = ~uop_valid_q | bus.ex_ready;
        id_ready = rst_n & ~bus.flush & (state_q == IDLE) & load_ok;
        accept   = bus.id_valid & id_ready;
        is_multi = (bus.id_ir[15:13] == 3'b011);
        src_mask = (state_q == IDLE) ? bus.id_ir[7:0] : mask_q;
        sel_idx  = pick(src_mask);
        rem_mask = src_mask & ~(8'b1 << sel_idx);
        uop_opc  = (state_q == IDLE) ? {3'b010, bus.id_ir[12]} : uop_ir_q[15:12];
        uop_ra   = (state_q == IDLE) ? bus.id_ir[11:9] : uop_ir_q[8:6];
        uop_k    = (state_q == IDLE) ? 3'd0 : k_q;
        uop16    = {uop_opc, sel_idx, uop_ra, 3'b000, uop_k};
    end

    // Sequencer FSM and micro-op output register; flush beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            k_q         <= '0;
            uop_ir_q    <= '0;
            uop_pc_q    <= '0;
            uop_valid_q <= 1'b0;
            uop_first_q <= 1'b0;
            uop_last_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            k_q         <= '0;
            uop_valid_q <= 1'b0;
            uop_first_q <= 1'b0;
            uop_last_q  <= 1'b0;
        end else if (load_ok) begin
            case (state_q)
                IDLE: begin
                    if (accept && is_multi && bus.id_ir[7:0] != 8'h00) begin
                        uop_ir_q    <= IR_W'(uop16);
                        uop_pc_q    <= bus.id_pc;
                        uop_valid_q <= 1'b1;
                        uop_first_q <= 1'b1;
                        uop_last_q  <= (rem_mask == 8'h00);
                        mask_q      <= rem_mask;
                        k_q         <= 3'd1;
                        state_q     <= (rem_mask != 8'h00) ? SEQ : IDLE;
                    end else if (accept && !is_multi) begin
                        uop_ir_q    <= bus.id_ir;
                        uop_pc_q    <= bus.id_pc;
                        uop_valid_q <= 1'b1;
                        uop_first_q <= 1'b0;
                        uop_last_q  <= 1'b1;
                    end else begin
                        // Nothing accepted, or an empty-list LM/SM swallowed.
                        uop_valid_q <= 1'b0;
                        uop_first_q <= 1'b0;
                        uop_last_q  <= 1'b0;
                    end
                end
                SEQ: begin
                    uop_ir_q    <= IR_W'(uop16);
                    uop_valid_q <= 1'b1;
                    uop_first_q <= 1'b0;
                    uop_last_q  <= (rem_mask == 8'h00);
                    mask_q      <= rem_mask;
                    k_q         <= k_q + 3'd1;
                    if (rem_mask == 8'h00) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.id_ready  = id_ready;
    assign bus.stall_if  = ~id_ready;
    assign bus.uop_valid = uop_valid_q;
    assign bus.uop_ir    = uop_ir_q;
    assign bus.uop_pc    = uop_pc_q;
    assign bus.uop_first = uop_first_q;
    assign bus.uop_last  = uop_last_q;
endmodule
